// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port word memory. Instruction fetch
// and load/store share one access per cycle; load/store normally wins, and
// fetch is forced through after STARVE_MAX consecutive lost cycles. Read
// data returns one cycle after the grant, steered by the registered owner.
//
// owner state | meaning
// ------------+---------------------------------------------------------
// OWN_NONE    | no read in flight; both rvalid outputs low next cycle
// OWN_IF      | fetch read granted last cycle; if_rvalid_o/if_rdata_o live
// OWN_LS      | load read granted last cycle; ls_rvalid_o/ls_rdata_o live
module mem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [3:0]    ls_be_i,
  input  logic [31:0]   ls_addr_i,
  input  logic [31:0]   ls_wdata_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [31:0]   ls_rdata_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_din_o,
  input  logic [31:0]   mem_dout_i,
  output logic [15:0]   conflict_cnt_o
);

  // One spare code above STARVE_MAX keeps the counter width sane for tiny values.
  localparam int SW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [15:0]   conflict_q, conflict_d;

  logic both_req;
  logic fetch_wins;
  logic if_gnt;
  logic ls_gnt;
  logic ls_store_gnt;

  // Word addressing drops the byte offset and anything above the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:AW+2], if_addr_i[1:0],
                              ls_addr_i[31:AW+2], ls_addr_i[1:0]};

  // Grant decision: combinational from requests and starvation state, masked in reset.
  always_comb begin
    both_req     = if_req_i & ls_req_i;
    fetch_wins   = (starve_q == SW'(STARVE_MAX));
    if_gnt       = rst_n_i & if_req_i & (~ls_req_i | fetch_wins);
    ls_gnt       = rst_n_i & ls_req_i & ~if_gnt;
    ls_store_gnt = ls_gnt & ls_we_i;
  end

  // State register: owner, starvation counter and conflict counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      owner_q    <= OWN_NONE;
      starve_q   <= '0;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  // Next-state logic; starvation is bounded because fetch wins at STARVE_MAX.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt && !ls_we_i) begin
      owner_d = OWN_LS;
    end

    starve_d = '0;
    if (if_req_i && !if_gnt) begin
      starve_d = starve_q + 1'b1;
    end

    conflict_d = conflict_q;
    if (both_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // Outputs: memory port follows the winner, read data steered by the owner.
  always_comb begin
    if_gnt_o    = if_gnt;
    ls_gnt_o    = ls_gnt;
    mem_en_o    = if_gnt | ls_gnt;
    mem_we_o    = ls_store_gnt ? ls_be_i : 4'b0000;
    mem_din_o   = ls_store_gnt ? ls_wdata_i : 32'h0;
    mem_addr_o  = '0;
    if (if_gnt) begin
      mem_addr_o = if_addr_i[AW+1:2];
    end else if (ls_gnt) begin
      mem_addr_o = ls_addr_i[AW+1:2];
    end

    // A read granted just before reset is dropped while reset is held.
    if_rvalid_o    = rst_n_i & (owner_q == OWN_IF);
    ls_rvalid_o    = rst_n_i & (owner_q == OWN_LS);
    if_rdata_o     = if_rvalid_o ? mem_dout_i : 32'h0;
    ls_rdata_o     = ls_rvalid_o ? mem_dout_i : 32'h0;
    conflict_cnt_o = conflict_q;
  end

endmodule
